// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V core.
// Drives a shared datapath and a single-ported unified memory.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_LOAD, C_STORE, C_ARI, C_ARR, C_BR
    } cls_t;

    state_t     state, state_nxt;
    cls_t       cls, cls_nxt, op_cls;
    logic       op_sys;
    logic       illegal_q, illegal_nxt;
    logic [1:0] alu_op_nxt;
    logic       mem_req_q, mem_we_q, addr_sel_q, branch_q, alu_src_q;
    logic [1:0] alu_op_q;
    logic       mem_to_reg_q, reg_write_q, retire_q, halted_q;

    always_comb begin
        op_cls = C_NONE;
        op_sys = 1'b0;
        case (op)
            5'b00000: op_cls = C_LOAD;
            5'b01000: op_cls = C_STORE;
            5'b00100: op_cls = C_ARI;
            5'b01100: op_cls = C_ARR;
            5'b11000: op_cls = C_BR;
            5'b11100: op_sys = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cls_nxt     = cls;
        illegal_nxt = illegal_q;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                cls_nxt = op_cls;
                if (op_cls != C_NONE) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt   = S_HALT;
                    illegal_nxt = !op_sys;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    C_BR:            state_nxt = S_FETCH;
                    default:         state_nxt = S_WB;
                endcase
            end
            S_MEM:    if (mem_ready) state_nxt = (cls == C_STORE) ? S_FETCH : S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op_nxt = 2'b00;
        if (state_nxt == S_EXEC) begin
            case (cls_nxt)
                C_ARI:   alu_op_nxt = 2'b11;
                C_ARR:   alu_op_nxt = 2'b10;
                C_BR:    alu_op_nxt = 2'b01;
                default: alu_op_nxt = 2'b00;
            endcase
        end
    end

    // Moore strobes are registered from the next state so they are valid
    // from the first cycle of each state without a decode stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            cls          <= C_NONE;
            illegal_q    <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            addr_sel_q   <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cls          <= cls_nxt;
            illegal_q    <= illegal_nxt;
            mem_req_q    <= (state_nxt == S_FETCH) || (state_nxt == S_MEM);
            mem_we_q     <= (state_nxt == S_MEM) && (cls_nxt == C_STORE);
            addr_sel_q   <= (state_nxt == S_MEM);
            branch_q     <= (state_nxt == S_EXEC) && (cls_nxt == C_BR);
            alu_src_q    <= (state_nxt == S_EXEC) &&
                            (cls_nxt inside {C_LOAD, C_STORE, C_ARI});
            alu_op_q     <= alu_op_nxt;
            mem_to_reg_q <= (state_nxt == S_WB) && (cls_nxt == C_LOAD);
            reg_write_q  <= (state_nxt == S_WB);
            retire_q     <= (state_nxt == S_WB) ||
                            ((state_nxt == S_EXEC) && (cls_nxt == C_BR));
            halted_q     <= (state_nxt == S_HALT);
        end
    end

    // Everything is forced low while rst is asserted, even mid-handshake.
    assign mem_req    = mem_req_q    & ~rst;
    assign mem_we     = mem_we_q     & ~rst;
    assign addr_sel   = addr_sel_q   & ~rst;
    assign branch     = branch_q     & ~rst;
    assign alu_src    = alu_src_q    & ~rst;
    assign alu_op     = alu_op_q     & {2{~rst}};
    assign mem_to_reg = mem_to_reg_q & ~rst;
    assign reg_write  = reg_write_q  & ~rst;
    assign halted     = halted_q     & ~rst;
    assign illegal    = illegal_q    & ~rst;
    assign ir_write   = ~rst & (state == S_FETCH) & mem_ready;
    assign pc_write   = ~rst & (state == S_FETCH) & mem_ready;
    assign retire     = ~rst & (retire_q |
                        ((state == S_MEM) & (cls == C_STORE) & mem_ready));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected-output sequences are
// built from the instruction timing rules and compared every cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] op = 5'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, branch, alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_write, retire, halted, illegal;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef logic [13:0] ovec_t;
    localparam ovec_t Z     = 14'd0;
    localparam ovec_t MREQ  = 14'd1 << 13;
    localparam ovec_t MWE   = 14'd1 << 12;
    localparam ovec_t ASEL  = 14'd1 << 11;
    localparam ovec_t IRW   = 14'd1 << 10;
    localparam ovec_t PCW   = 14'd1 << 9;
    localparam ovec_t BR    = 14'd1 << 8;
    localparam ovec_t ASRC  = 14'd1 << 7;
    localparam ovec_t AOP01 = 14'd1 << 5;
    localparam ovec_t AOP10 = 14'd2 << 5;
    localparam ovec_t AOP11 = 14'd3 << 5;
    localparam ovec_t M2R   = 14'd1 << 4;
    localparam ovec_t RW    = 14'd1 << 3;
    localparam ovec_t RET   = 14'd1 << 2;
    localparam ovec_t HLT   = 14'd1 << 1;
    localparam ovec_t ILL   = 14'd1;

    ovec_t act;
    assign act = {mem_req, mem_we, addr_sel, ir_write, pc_write, branch, alu_src,
                  alu_op, mem_to_reg, reg_write, retire, halted, illegal};

    typedef struct {
        string nm;
        int    got;
        int    want;
    } pin_t;

    ovec_t      exp_q[$];
    logic       rdy_q[$];
    logic       rst_q[$];
    logic [4:0] op_q[$];
    pin_t       pin_q[$];
    int         ret_cyc[int];

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    ovec_t       cur_exp = '0;
    logic        cur_valid = 1'b0;
    int          cyc = 0;
    int          run_id = 0;
    string       tname = "reset";

    // The only process that evaluates comparisons.
    always @(negedge clk) begin
        if (cur_valid) begin
            n_checks++;
            if (act !== cur_exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs got %b want %b", tname, cyc, act, cur_exp);
            end
            if (retire === 1'b1) ret_cyc[run_id] = cyc;
        end
        while (pin_q.size() > 0) begin
            pin_t p;
            p = pin_q.pop_front();
            n_checks++;
            if (p.got != p.want) begin
                n_fail++;
                $display("FAIL %s: got %0d want %0d", p.nm, p.got, p.want);
            end
        end
    end

    task automatic push(input logic [4:0] o, input logic r, input logic rs, input ovec_t e);
        op_q.push_back(o);
        rdy_q.push_back(r);
        rst_q.push_back(rs);
        exp_q.push_back(e);
    endtask

    // Expected sequence for one instruction; len counts cycles to retire.
    task automatic gen(input logic [4:0] o, input logic [4:0] ol, input int fw,
                       input int mw, input bit abort, output int len);
        bit is_ld, is_st;
        len = 0;
        for (int i = 0; i < fw; i++) begin push(o, 1'b0, 1'b0, MREQ); len++; end
        push(o, 1'b1, 1'b0, MREQ | IRW | PCW); len++;
        push(o, 1'b1, 1'b0, Z); len++;
        is_ld = (o == 5'b00000);
        is_st = (o == 5'b01000);
        if (is_ld || is_st) begin
            push(ol, 1'b1, 1'b0, ASRC); len++;
            for (int i = 0; i < mw; i++) begin
                push(ol, 1'b0, 1'b0, MREQ | ASEL | (is_st ? MWE : Z)); len++;
            end
            if (abort) return;
            push(ol, 1'b1, 1'b0, MREQ | ASEL | (is_st ? (MWE | RET) : Z)); len++;
            if (is_ld) begin push(ol, 1'b1, 1'b0, RW | RET | M2R); len++; end
        end else if (o == 5'b00100 || o == 5'b01100) begin
            push(ol, 1'b1, 1'b0, (o == 5'b00100) ? (ASRC | AOP11) : AOP10); len++;
            push(ol, 1'b1, 1'b0, RW | RET); len++;
        end else if (o == 5'b11000) begin
            push(ol, 1'b1, 1'b0, BR | AOP01 | RET); len++;
        end else begin
            for (int i = 0; i < 21; i++)
                push(ol, 1'b1, 1'b0, HLT | ((o == 5'b11100) ? Z : ILL));
        end
    endtask

    task automatic run(input string nm);
        tname = nm;
        run_id++;
        cyc = 0;
        while (exp_q.size() > 0) begin
            op        = op_q.pop_front();
            mem_ready = rdy_q.pop_front();
            rst       = rst_q.pop_front();
            cur_exp   = exp_q.pop_front();
            cur_valid = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input string nm, input int got, input int want);
        pin_t p;
        p.nm = nm;
        p.got = got;
        p.want = want;
        pin_q.push_back(p);
    endtask

    function automatic int retired_at(input int id);
        return ret_cyc.exists(id) ? ret_cyc[id] : -1;
    endfunction

    initial begin
        int len;
        @(posedge clk);
        #1;
        push(5'b0, 1'b1, 1'b1, Z);
        push(5'b0, 1'b0, 1'b1, Z);
        run("reset");

        // Live op flips to Branch after DECODE; captured class must hold.
        gen(5'b01100, 5'b11000, 0, 0, 1'b0, len);
        pin("arith_r_model_len", len, 4);
        run("arith_r");
        pin("arith_r_retire_cycle", retired_at(run_id), 4);

        gen(5'b00000, 5'b00000, 2, 3, 1'b0, len);
        pin("load_model_len", len, 10);
        run("load_waits");
        pin("load_retire_cycle", retired_at(run_id), 10);

        gen(5'b01000, 5'b01000, 0, 1, 1'b0, len);
        run("store");
        pin("store_retire_cycle", retired_at(run_id), 5);

        gen(5'b11000, 5'b11000, 0, 0, 1'b0, len);
        pin("branch_model_len", len, 3);
        run("branch");
        pin("branch_retire_cycle", retired_at(run_id), 3);

        gen(5'b00100, 5'b00100, 1, 0, 1'b0, len);
        run("arith_i");
        pin("arith_i_retire_cycle", retired_at(run_id), 5);

        gen(5'b11100, 5'b11100, 0, 0, 1'b0, len);
        push(5'b0, 1'b1, 1'b1, Z);
        run("system_halt");
        pin("system_no_retire", retired_at(run_id), -1);

        gen(5'b01101, 5'b01101, 0, 0, 1'b0, len);
        push(5'b0, 1'b1, 1'b1, Z);
        gen(5'b00000, 5'b00000, 0, 2, 1'b1, len);
        push(5'b00000, 1'b0, 1'b1, Z);
        run("illegal_then_rst_in_mem");
        pin("aborted_no_retire", retired_at(run_id), -1);

        gen(5'b01000, 5'b01000, 0, 0, 1'b0, len);
        pin("store_model_len", len, 4);
        run("store_after_rst");
        pin("store_after_rst_retire", retired_at(run_id), 4);

        cur_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RISC-V core. Drives a shared PC/IR/ALU/register-file datapath and one single-ported unified memory through a fetch–decode–execute–memory–writeback state machine. Per-instruction control strobes are decoded from the 5-bit opcode field, instr[6:2]. Replaces the single-cycle combinational decode when instruction and data traffic share one memory port.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  5  instr[6:2] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  request is a write (Store only).
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result register.
- ir_write  out  1  latch memory read data into the IR.
- pc_write  out  1  unconditional PC update with PC+4.
- branch  out  1  conditional PC update; datapath ANDs it with the ALU zero flag.
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- alu_op  out  2  00 add, 01 subtract/compare, 10 R-type funct decode, 11 I-type funct decode.
- mem_to_reg  out  1  writeback source: 1 = memory data register, 0 = ALU.
- reg_write  out  1  register-file write enable.
- retire  out  1  one-cycle pulse on an instruction's final cycle.
- halted  out  1  core stopped (SYSTEM opcode or illegal opcode).
- illegal  out  1  halt caused by an unsupported opcode.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are decoded from the state (Moore), except ir_write/pc_write, which are qualified by mem_ready.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ready, ir_write=1, pc_write=1, and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE: no strobes. Next state by op:
  - 00000 Load, 01000 Store, 00100 Arith_I, 01100 Arith_R, 11000 Branch → EXEC.
  - 11100 SYSTEM → HALT.
  - Any other value → HALT with illegal set.
- EXEC:
  - Load/Store: alu_src=1, alu_op=00 → MEM.
  - Arith_I: alu_src=1, alu_op=11 → WB.
  - Arith_R: alu_src=0, alu_op=10 → WB.
  - Branch: alu_src=0, alu_op=01, branch=1, retire=1 → FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for Store and 0 for Load.
  - Waits for mem_ready.
  - Load → WB.
  - Store: retire=1 in the completing cycle → FETCH.
- WB: reg_write=1, retire=1 → FETCH. mem_to_reg=1 for Load, 0 for Arith.
- The opcode class is captured into an internal register in DECODE. EXEC, MEM and WB use the captured class, not the live op.
- HALT: absorbing. halted=1; all strobes 0. Exits only on rst.
- illegal is set on entry to HALT from an unsupported opcode and cleared only by rst.
- Any state and output not listed above is 0.

## Timing
- Reset: rst high at an edge forces state=FETCH and clears illegal and the captured class.
  - While rst is high, every output is 0.
  - The first cycle after rst falls is FETCH with mem_req=1.
- Reset mid-instruction (including mid-handshake): the instruction is abandoned, no strobe is issued, and the FSM restarts in FETCH.
- mem_req must stay high and mem_we/addr_sel stable until the cycle in which mem_ready=1. The request is complete in that cycle.
- mem_ready while mem_req=0 is ignored.
- Cycle counts with zero-wait memory (mem_ready always 1), from FETCH entry to retire inclusive:
  - Branch: 3
  - Arith_I/R: 4
  - Store: 4
  - Load: 5
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- retire is high for exactly one cycle per instruction. It is never asserted for SYSTEM or illegal instructions.
- Exactly one pc_write per fetched instruction.

## Test plan
- Arith_R (op=01100), mem_ready=1: FETCH/DECODE/EXEC/WB.
  - ir_write=pc_write=1 in cycle 1.
  - alu_op=10, alu_src=0 in cycle 3.
  - reg_write=retire=1, mem_to_reg=0 in cycle 4.
  - FETCH again in cycle 5.
- Load (00000) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM:
  - mem_req held throughout each wait, addr_sel 0 then 1, mem_we=0.
  - reg_write=mem_to_reg=1 in WB.
  - retire at cycle 5+2+3=10.
- Store (01000): MEM has mem_we=1, addr_sel=1; retire asserted in the mem_ready cycle; reg_write never high; next FETCH follows.
- Branch (11000): branch=1, alu_op=01, retire=1 in cycle 3; reg_write and mem_req low in EXEC.
- op=11100 → HALT with halted=1, illegal=0. op=01101 → HALT with halted=1, illegal=1. In both cases, 20 further cycles with mem_ready=1 produce no strobes.
- rst pulsed in MEM with mem_ready=0:
  - All outputs are 0 during rst.
  - The next cycle is FETCH with mem_req=1 and addr_sel=0.
  - halted and illegal are cleared after a prior illegal halt.
